// File: rtl/seq_detector_param_if.sv
// Bus bundle for seq_detector_param: serial input strobe, pattern load,
// overlap select, counter clear, and the registered match/progress/count outputs.
interface seq_detector_param_if #(
    parameter int LEN         = 4,
    parameter int COUNT_WIDTH = 8
);
    localparam int PW = $clog2(LEN);

    logic                   In;
    logic                   InValid;
    logic                   Overlap;
    logic                   Load;
    logic [LEN-1:0]         PatternIn;
    logic                   CountClear;
    logic                   Out;
    logic [PW-1:0]          Progress;
    logic [COUNT_WIDTH-1:0] MatchCount;

    modport master (
        output In, InValid, Overlap, Load, PatternIn, CountClear,
        input  Out, Progress, MatchCount
    );

    modport slave (
        input  In, InValid, Overlap, Load, PatternIn, CountClear,
        output Out, Progress, MatchCount
    );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with runtime pattern, overlap select and progress output.
// Define SEQDET_MATCH_COUNT_EN to build the saturating MatchCount register and CountClear.
module seq_detector_param #(
    parameter int             LEN             = 4,
    parameter logic [LEN-1:0] DEFAULT_PATTERN = 4'b1010,
    parameter int             COUNT_WIDTH     = 8
) (
    input logic                Clock,
    input logic                Reset,
    seq_detector_param_if.slave bus
);
    localparam int             PW        = $clog2(LEN);
    localparam int             FW        = $clog2(LEN + 1);
    localparam logic [FW-1:0]  FILL_FULL = FW'(LEN);

    logic [LEN-1:0] pat_q, pat_d;
    logic [LEN-1:0] hist_q, hist_d;
    logic [FW-1:0]  fill_q, fill_d;
    logic           out_q, out_d;
    logic [PW-1:0]  progress_q, progress_d;

    logic [LEN-1:0] new_hist;
    logic [FW-1:0]  new_fill;
    logic           match;

    // Longest pattern prefix (below LEN) that the newest stored bits currently spell out.
    function automatic logic [PW-1:0] prefix_len(
        input logic [LEN-1:0] hist,
        input logic [LEN-1:0] pat,
        input logic [FW-1:0]  fill
    );
        logic [PW-1:0]  best;
        logic [LEN-1:0] mask;
        best = '0;
        for (int k = 1; k < LEN; k++) begin
            mask = (LEN'(1) << k) - LEN'(1);
            if ((FW'(k) <= fill) && ((hist & mask) == (pat >> (LEN - k)))) begin
                best = PW'(k);
            end
        end
        return best;
    endfunction

    always_comb begin
        pat_d    = pat_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        out_d    = 1'b0;
        match    = 1'b0;
        new_hist = {hist_q[LEN-2:0], bus.In};
        new_fill = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FW'(1);

        if (bus.Load) begin
            pat_d  = bus.PatternIn;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.InValid) begin
            // Fill guard keeps reset/cleared zeros from ever completing a match.
            match = (new_fill == FILL_FULL) && (new_hist == pat_q);
            out_d = match;
            if (match && !bus.Overlap) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = new_hist;
                fill_d = new_fill;
            end
        end

        progress_d = prefix_len(hist_d, pat_d, fill_d);
    end

    // State register stage: every flop takes its next value on the sampling edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pat_q      <= DEFAULT_PATTERN;
            hist_q     <= '0;
            fill_q     <= '0;
            out_q      <= 1'b0;
            progress_q <= '0;
        end else begin
            pat_q      <= pat_d;
            hist_q     <= hist_d;
            fill_q     <= fill_d;
            out_q      <= out_d;
            progress_q <= progress_d;
        end
    end

    assign bus.Out      = out_q;
    assign bus.Progress = progress_q;

`ifdef SEQDET_MATCH_COUNT_EN
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic [COUNT_WIDTH-1:0] count_q, count_d;

    // Clear wins over a coincident match; load also restarts the count.
    always_comb begin
        count_d = count_q;
        if (bus.Load || bus.CountClear) begin
            count_d = '0;
        end else if (match && (count_q != COUNT_MAX)) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.MatchCount = count_q;
`else
    logic unused_count_clear;
    assign unused_count_clear = bus.CountClear;
    assign bus.MatchCount     = '0;
`endif

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial bit-pattern detector, the successor to the fixed 4-bit "1010" detector FSM.
- Pattern length is a parameter; the pattern value is runtime-loadable.
- Overlapping or non-overlapping detection is selectable at run time.
- Inputs are qualified by a valid strobe.
- Reports match progress and keeps a saturating match counter.
- Sits on a serial bit stream in front of framing/sync logic.

Parameters:
LEN, 4, pattern length in bits; legal range 2..16.
DEFAULT_PATTERN, 4'b1010, pattern register value after reset; LEN bits wide; MSB is the first bit expected.
COUNT_WIDTH, 8, width of the MatchCount register.
PW, $clog2(LEN), width of Progress; derived localparam, not overridable.

Ports:
Clock  input  1  system clock; all state changes on rising edge.
Reset  input  1  asynchronous, active-high reset.
In  input  1  serial data bit.
InValid  input  1  In is sampled only when high.
Overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every edge.
Load  input  1  load PatternIn into the pattern register.
PatternIn  input  LEN  new pattern; MSB is the first bit expected.
Out  output  1  registered match pulse.
Progress  output  PW  registered count of pattern prefix bits currently matched (0..LEN-1).
MatchCount  output  COUNT_WIDTH  saturating number of matches since reset, load or clear.
CountClear  input  1  synchronous clear of MatchCount.

Behaviour:
- Reset (asynchronous, takes effect immediately): Pat=DEFAULT_PATTERN, Hist=0, Fill=0, Out=0, Progress=0, MatchCount=0.
- Internal state:
  - Hist: LEN-bit shift register; newest bit in bit 0.
  - Fill: valid-bit count, saturating at LEN.
  - Pat: the pattern register.
- Edge priority: Load > InValid > idle.
- Load=1:
  - Pat<=PatternIn; Hist<=0; Fill<=0; Out<=0; Progress<=0; MatchCount<=0.
  - In is ignored that cycle.
- InValid=1, Load=0:
  - NewHist={Hist[LEN-2:0],In}; NewFill=min(Fill+1,LEN).
  - Match = (NewFill==LEN) && (NewHist==Pat).
  - Out<=Match on the same edge that samples the completing bit; latency 0 cycles after the sampling edge. Out is high for exactly one cycle per match.
  - On Match with Overlap=1: Hist<=NewHist; Fill<=LEN.
  - On Match with Overlap=0: Hist<=0; Fill<=0, so no bit of the matched window is reused.
  - No match: Hist<=NewHist; Fill<=NewFill.
  - Progress<= largest k in 0..LEN-1 such that k<=stored Fill and the newest k stored bits equal Pat[LEN-1:LEN-k]. After a non-overlap match this is 0.
- InValid=0, Load=0: all state holds; Out<=0.
- MatchCount:
  - Increments on each Match and saturates at 2^COUNT_WIDTH-1.
  - CountClear=1 forces it to 0. If CountClear and Match occur on the same edge, the result is 0.
- A match needs LEN genuinely received bits; reset/cleared zeros never produce a match.
- Overlap change mid-stream affects only the match decision on the edge it is sampled.
- Progress is combinational from the next-state values and stored in a register. This is the generalised equivalent of the old State output.

Optional Feature:
SEQDET_MATCH_COUNT_EN
- Defined: the MatchCount register and CountClear logic are present as described above.
- Undefined: no counter register is built; MatchCount is tied to 0 and CountClear is ignored. All other behaviour is unchanged.

Test Plan:
1. LEN=4, default pattern 1010, Overlap=1, stream 1,0,1,0,1,0 (InValid=1 each cycle) -> Out pulses after bits 4 and 6; MatchCount=2; Progress sequence 1,2,3,2,3,2.
2. Same stream, Overlap=0 -> Out pulses only after bit 4; MatchCount=1; Progress after bit 6 = 2.
3. Stream 1,0,[InValid=0 for 3 cycles],1,0 -> Out pulses once, on the edge sampling the final 0; Out=0 and Progress held at 2 during the gap.
4. Load PatternIn=0110 after bits 1,0,1 of an in-progress 1010 -> Progress=0, MatchCount=0; then stream 0,1,1,0 -> Out pulses after the 4th bit.
5. COUNT_WIDTH=2, Overlap=1, stream 1010101010 -> four matches; MatchCount saturates at 3. CountClear coincident with the next match -> MatchCount=0.
6. Assert Reset asynchronously mid-stream after bits 1,0,1 -> Out, Progress and MatchCount go to 0 immediately. After release, stream 0 -> no match (Fill=1). Then 1,0,1,0 -> match on the 4th bit.
